// File: rtl/command_mode_fsm.sv
// command_mode_fsm: confirms mode commands from a link, handles STOP and link-loss fallback
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous active-high reset
//   cmd_data     in   [CMD_W] command word, sampled when cmd_valid is high
//   cmd_valid    in   one command beat
//   mode_onehot  out  [NUM_MODES] active mode, zero in INIT/STOP
//   mode_idx     out  index of active mode, zero when none active
//   stopped      out  high while in STOP
//   mode_changed out  one-cycle pulse when mode_onehot changes
//   link_lost    out  set by idle timeout, cleared by the next beat
//   cmd_error    out  one-cycle pulse per unrecognised beat
module command_mode_fsm #(
    parameter int CMD_W       = 8,
    parameter int NUM_MODES   = 4,
    parameter int CONFIRM_N   = 3,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CMD_W-1:0]             cmd_data,
    input  logic                         cmd_valid,
    output logic [NUM_MODES-1:0]         mode_onehot,
    output logic [$clog2(NUM_MODES)-1:0] mode_idx,
    output logic                         stopped,
    output logic                         mode_changed,
    output logic                         link_lost,
    output logic                         cmd_error
);
    localparam int IW = $clog2(NUM_MODES);
    localparam int CW = $clog2(CONFIRM_N + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {INIT, ACTIVE, STOP} state_t;

    state_t               state, state_d;
    logic [IW-1:0]        idx_d;
    logic [CMD_W-1:0]     code, code_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [TW-1:0]        idle, idle_d;
    logic [NUM_MODES-1:0] onehot_d;
    logic                 is_stop, is_mode, same, accept, timeout, lost_d;

    always_comb begin
        is_stop = &cmd_data;
        is_mode = cmd_data < CMD_W'(NUM_MODES);
        same    = (cnt != '0) && (code == cmd_data);
        cnt_d   = cnt;
        code_d  = code;
        if (cmd_valid) begin
            if (!is_mode) cnt_d = '0;
            else if (!same) begin
                cnt_d  = CW'(1);
                code_d = cmd_data;
            end else if (cnt != CW'(CONFIRM_N)) cnt_d = cnt + CW'(1);
        end
        // a saturated count on the same code must not accept again
        accept  = cmd_valid && is_mode && (cnt_d == CW'(CONFIRM_N)) && !(same && cnt == CW'(CONFIRM_N));
        idle_d  = cmd_valid ? '0 : (idle == TW'(TIMEOUT_CYC)) ? idle : idle + TW'(1);
        // fires only on the edge where the counter reaches the limit; a beat suppresses it
        timeout = !cmd_valid && (idle == TW'(TIMEOUT_CYC - 1));
        lost_d  = cmd_valid ? 1'b0 : timeout ? 1'b1 : link_lost;
        state_d = state;
        idx_d   = mode_idx;
        if (cmd_valid && is_stop) begin
            state_d = STOP;
            idx_d   = '0;
        end else if (accept && (state == ACTIVE || cmd_data == CMD_W'(0))) begin
            state_d = ACTIVE;
            idx_d   = cmd_data[IW-1:0];
        end else if (timeout && state == ACTIVE) begin
            idx_d = '0;
            cnt_d = '0;
        end
        onehot_d = (state_d == ACTIVE) ? NUM_MODES'(1) << idx_d : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= INIT;
            code         <= '0;
            cnt          <= '0;
            idle         <= '0;
            mode_onehot  <= '0;
            mode_idx     <= '0;
            stopped      <= 1'b0;
            mode_changed <= 1'b0;
            link_lost    <= 1'b0;
            cmd_error    <= 1'b0;
        end else begin
            state        <= state_d;
            code         <= code_d;
            cnt          <= cnt_d;
            idle         <= idle_d;
            mode_onehot  <= onehot_d;
            mode_idx     <= idx_d;
            stopped      <= state_d == STOP;
            mode_changed <= onehot_d != mode_onehot;
            link_lost    <= lost_d;
            cmd_error    <= cmd_valid && !is_stop && !is_mode;
        end
    end
endmodule

// File: tb/tb_command_mode_fsm.sv
// tb_command_mode_fsm: table-driven scoreboard bench for command_mode_fsm
module tb_command_mode_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cmd_data = '0;
    logic       cmd_valid = 1'b0;
    logic [3:0] mode_onehot;
    logic [1:0] mode_idx;
    logic       stopped, mode_changed, link_lost, cmd_error;

    command_mode_fsm #(.TIMEOUT_CYC(10)) dut (
        .clk(clk), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .mode_onehot(mode_onehot), .mode_idx(mode_idx), .stopped(stopped),
        .mode_changed(mode_changed), .link_lost(link_lost), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [9:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [9:0] sb[$];
    int         checks = 0;
    int         errors = 0;
    int         popped = 0;

    wire [9:0] got = {mode_onehot, mode_idx, stopped, mode_changed, link_lost, cmd_error};

    function automatic void add(logic v, logic [7:0] d, logic [3:0] o, logic [1:0] i,
                                logic s, logic c, logic l, logic e);
        tbl.push_back('{v, d, {o, i, s, c, l, e}});
    endfunction

    task automatic drive(logic v, logic [7:0] d, logic [9:0] exp);
        @(negedge clk);
        cmd_valid = v;
        cmd_data  = d;
        sb.push_back(exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            logic [9:0] e;
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL step%0d outputs got=%b want=%b (onehot,idx,stop,chg,lost,err)", popped, got, e);
            end
            popped++;
        end
    end

    initial begin
        // reset release and confirmation of mode 0
        add(1, 8'h00, 4'h0, 0, 0, 0, 0, 0);
        add(1, 8'h00, 4'h0, 0, 0, 0, 0, 0);
        add(1, 8'h00, 4'h1, 0, 0, 1, 0, 0);
        add(0, 8'h00, 4'h1, 0, 0, 0, 0, 0);
        // interrupted confirmation toward mode 2
        add(1, 8'h02, 4'h1, 0, 0, 0, 0, 0);
        add(1, 8'h02, 4'h1, 0, 0, 0, 0, 0);
        add(1, 8'h01, 4'h1, 0, 0, 0, 0, 0);
        add(1, 8'h02, 4'h1, 0, 0, 0, 0, 0);
        add(1, 8'h02, 4'h1, 0, 0, 0, 0, 0);
        add(1, 8'h02, 4'h4, 2, 0, 1, 0, 0);
        add(1, 8'h02, 4'h4, 2, 0, 0, 0, 0);
        // STOP on one beat, only mode 0 exits
        add(1, 8'hFF, 4'h0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 8'h01, 4'h0, 0, 1, 0, 0, 0);
        add(1, 8'h00, 4'h0, 0, 1, 0, 0, 0);
        add(1, 8'h00, 4'h0, 0, 1, 0, 0, 0);
        add(1, 8'h00, 4'h1, 0, 0, 1, 0, 0);
        // unrecognised code clears the count
        add(1, 8'h01, 4'h1, 0, 0, 0, 0, 0);
        add(1, 8'h01, 4'h1, 0, 0, 0, 0, 0);
        add(1, 8'h7E, 4'h1, 0, 0, 0, 0, 1);
        add(1, 8'h01, 4'h1, 0, 0, 0, 0, 0);
        add(1, 8'h01, 4'h1, 0, 0, 0, 0, 0);
        add(1, 8'h01, 4'h2, 1, 0, 1, 0, 0);
        // mode 3 then idle timeout
        add(1, 8'h03, 4'h2, 1, 0, 0, 0, 0);
        add(1, 8'h03, 4'h2, 1, 0, 0, 0, 0);
        add(1, 8'h03, 4'h8, 3, 0, 1, 0, 0);
        for (int k = 0; k < 9; k++) add(0, 8'h00, 4'h8, 3, 0, 0, 0, 0);
        add(0, 8'h00, 4'h1, 0, 0, 1, 1, 0);
        add(0, 8'h00, 4'h1, 0, 0, 0, 1, 0);
        add(1, 8'h7E, 4'h1, 0, 0, 0, 0, 1);
        // beat on the would-be timeout cycle wins
        for (int k = 0; k < 9; k++) add(0, 8'h00, 4'h1, 0, 0, 0, 0, 0);
        add(1, 8'h01, 4'h1, 0, 0, 0, 0, 0);
        add(0, 8'h00, 4'h1, 0, 0, 0, 0, 0);
        // timeout in STOP only sets link_lost
        add(1, 8'hFF, 4'h0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 9; k++) add(0, 8'h00, 4'h0, 0, 1, 0, 0, 0);
        add(0, 8'h00, 4'h0, 0, 1, 0, 1, 0);
        add(1, 8'h00, 4'h0, 0, 1, 0, 0, 0);
        add(1, 8'h00, 4'h0, 0, 1, 0, 0, 0);
        add(1, 8'h00, 4'h1, 0, 0, 1, 0, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (got !== 10'b0) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", got, 10'b0);
        end
        reset = 1'b0;

        foreach (tbl[n]) drive(tbl[n].v, tbl[n].d, tbl[n].exp);

        // async reset mid-confirmation discards progress
        drive(1, 8'h01, {4'h1, 2'd0, 4'b0000});
        drive(1, 8'h01, {4'h1, 2'd0, 4'b0000});
        @(posedge clk);
        #3;
        cmd_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (got !== 10'b0) begin
            errors++;
            $display("FAIL async_reset got=%b want=%b", got, 10'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) drive(1, 8'h01, 10'b0);
        drive(1, 8'h00, 10'b0);
        drive(1, 8'h00, 10'b0);
        drive(1, 8'h00, {4'h1, 2'd0, 4'b0100});
        drive(0, 8'h00, {4'h1, 2'd0, 4'b0000});

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
